// File: rtl/alu_muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fixed up at the end.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH-1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, bzero_q, ovfc_q, qneg_q, rneg_q;
  logic [WIDTH-1:0]   araw_q, amag_q, bmag_q, work_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q, ovf_q;

  logic               accept, dwrite;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               qbit;
  logic [2*WIDTH-1:0] step_acc, prod;
  logic [WIDTH-1:0]   step_work, quo, rem;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy   = (state_q != IDLE);
    accept = (state_q == IDLE) && start;
    dwrite = (state_q == IDLE) && !start;
  end

  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign ovf      = ovf_q;

  // Operand magnitudes; op[0] selects signed interpretation
  always_comb begin
    a_neg = op[0] & A[WIDTH-1];
    b_neg = op[0] & B[WIDTH-1];
    a_abs = a_neg ? -A : A;
    b_abs = b_neg ? -B : B;
  end

  // One iteration: multiply shifts the product right, divide shifts the dividend left
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, amag_q} : '0);
    div_sh    = {acc_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, bmag_q};
    qbit      = ~div_diff[WIDTH];
    if (is_div_q) begin
      step_acc  = {(qbit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
      step_work = work_q << 1;
    end else begin
      step_acc  = {mul_sum, acc_q[WIDTH-1:1]};
      step_work = work_q >> 1;
    end
    prod = qneg_q ? -acc_q : acc_q;
    quo  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
      ovfc_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      araw_q   <= '0;
      amag_q   <= '0;
      bmag_q   <= '0;
      work_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            is_div_q <= op[1];
            araw_q   <= A;
            amag_q   <= a_abs;
            bmag_q   <= b_abs;
            work_q   <= op[1] ? a_abs : b_abs;
            acc_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            bzero_q  <= (B == '0);
            ovfc_q   <= (op == 2'b11) && (A == MIN_V) && (B == '1);
          end else if (dwrite) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        CALC: begin
          acc_q  <= step_acc;
          work_q <= step_work;
          cnt_q  <= cnt_q + 1'b1;
        end
        FIX: begin
          dz_q  <= is_div_q & bzero_q;
          ovf_q <= is_div_q & ovfc_q & ~bzero_q;
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod;
          end else if (bzero_q) begin
            hi_q <= araw_q;
            lo_q <= '1;
          end else if (ovfc_q) begin
            hi_q <= '0;
            lo_q <= MIN_V;
          end else begin
            hi_q <= rem;
            lo_q <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: driver pushes expected results, a negedge monitor pops on done.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic         clk = 0, reset = 0, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0]   op = 0;
  logic [W-1:0] A = 0, B = 0, wdata = 0;
  logic         busy, done, div_zero, ovf;
  logic [W-1:0] hi, lo;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero), .ovf(ovf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dz, ovf;
    int           cyc;
  } exp_t;

  exp_t         scb[$];
  exp_t         mon_e;
  int           n_vec = 0, n_err = 0;
  logic [W-1:0] m_hi = 0, m_lo = 0;
  logic         m_dz = 0, m_ovf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the architectural rules
  function automatic exp_t ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    longint pa, pb;
    int sa, sbv;
    e.dz = 0; e.ovf = 0; e.cyc = 0;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = p; end
      2'b01: begin
        pa = longint'($signed(a)); pb = longint'($signed(b));
        p = 64'(pa * pb); {e.hi, e.lo} = p;
      end
      2'b10: begin
        if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: begin
        sa = $signed(a); sbv = $signed(b);
        if (b == 0) begin e.hi = a; e.lo = '1; e.dz = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.hi = 0; e.lo = 32'h8000_0000; e.ovf = 1; end
        else begin e.lo = sa / sbv; e.hi = sa % sbv; end
      end
    endcase
    return e;
  endfunction

  // Called just after a posedge; start is sampled on the following edge
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = ref_model(o, a, b);
    e.cyc = cyc + 1 + W + 1;
    scb.push_back(e);
    m_hi = e.hi; m_lo = e.lo; m_dz = e.dz; m_ovf = e.ovf;
    op = o; A = a; B = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    op = 2'($urandom_range(0, 3)); A = $urandom; B = $urandom;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (scb.size() != 0 && t < 200) begin @(posedge clk); t++; end
    #1;
    if (scb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", scb.size());
      scb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (scb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
      end else begin
        mon_e = scb.pop_front();
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
        chk("div_zero", div_zero, mon_e.dz);
        chk("ovf", ovf, mon_e.ovf);
        chk("latency", cyc, mon_e.cyc);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           sel;

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_dz", div_zero, 0); chk("rst_ovf", ovf, 0);
    reset = 1;
    @(posedge clk); #1;

    // MULTU with explicit done timing
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (W) @(posedge clk); #1;
    chk("pre_done_busy", busy, 1); chk("pre_done_done", done, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1); chk("done_busy", busy, 0);
    wait_drain();
    chk("multu_hi", hi, 32'hFFFF_FFFE); chk("multu_lo", lo, 32'h0000_0001);
    chk("done_one_cycle", done, 0);

    issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0007); wait_drain();
    chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFEB);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000); wait_drain();
    chk("mult_min_hi", hi, 32'h4000_0000); chk("mult_min_lo", lo, 32'h0);

    issue(2'b11, 32'hFFFF_FFF9, 32'h2); wait_drain();
    chk("div_lo", lo, 32'hFFFF_FFFD); chk("div_hi", hi, 32'hFFFF_FFFF);

    // hi_we coincident with start: start wins
    hi_we = 1; wdata = 32'hDEAD_BEEF;
    issue(2'b10, 32'h7, 32'h2);
    hi_we = 0;
    wait_drain();
    chk("divu_lo", lo, 32'h3); chk("divu_hi", hi, 32'h1);
    chk("divu_dz", div_zero, 0); chk("divu_ovf", ovf, 0);

    issue(2'b10, 32'h1234_5678, 32'h0); wait_drain();
    chk("dz_hi", hi, 32'h1234_5678); chk("dz_lo", lo, 32'hFFFF_FFFF); chk("dz_flag", div_zero, 1);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_drain();
    chk("ovf_lo", lo, 32'h8000_0000); chk("ovf_hi", hi, 32'h0); chk("ovf_flag", ovf, 1);

    // start and hi_we while busy are ignored
    issue(2'b01, 32'h0000_1234, 32'hFFFF_5678);
    repeat (4) @(posedge clk); #1;
    start = 1; op = 2'b10; hi_we = 1; wdata = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    start = 0; hi_we = 0;
    wait_drain();
    repeat (3) @(posedge clk); #1;
    chk("busy_ign_hi", hi, m_hi); chk("busy_ign_lo", lo, m_lo);

    // direct LO write in IDLE
    wdata = 32'h5555_5555; lo_we = 1;
    @(posedge clk); #1;
    lo_we = 0; m_lo = 32'h5555_5555;
    chk("mtlo_lo", lo, 32'h5555_5555); chk("mtlo_hi", hi, m_hi);
    chk("mtlo_dz", div_zero, m_dz); chk("mtlo_ovf", ovf, m_ovf);

    // reset mid-divide
    issue(2'b11, 32'h8765_4321, 32'h0000_0123);
    repeat (9) @(posedge clk);
    #2 reset = 0;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_hi", hi, 0); chk("mid_rst_lo", lo, 0);
    chk("mid_rst_dz", div_zero, 0); chk("mid_rst_ovf", ovf, 0);
    scb.delete();
    m_hi = 0; m_lo = 0; m_dz = 0; m_ovf = 0;
    @(posedge clk); #1;
    reset = 1;
    repeat (2) @(posedge clk); #1;

    // back-to-back: second start in the done cycle
    issue(2'b10, 32'd100, 32'd7);
    repeat (W + 1) @(posedge clk); #1;
    chk("b2b_done", done, 1);
    issue(2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    wait_drain();
    chk("b2b_lo", lo, 32'd30); chk("b2b_hi", hi, 32'd0);

    // randomized operations with occasional direct writes
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      ra = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      sel = $urandom_range(0, 5);
      rb = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF :
           (sel == 2) ? 32'($urandom_range(1, 15)) : $urandom;
      issue(ro, ra, rb);
      wait_drain();
      if ($urandom_range(0, 3) == 0) begin
        hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1));
        wdata = $urandom;
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        @(posedge clk); #1;
        hi_we = 0; lo_we = 0;
        chk("rnd_mt_hi", hi, m_hi); chk("rnd_mt_lo", lo, m_lo);
        chk("rnd_mt_dz", div_zero, m_dz);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
